// File: rtl/snax_tcdm_pkg.sv
// Shared TCDM types, default widths and address-decode constants for the
// SNAX TCDM responder and its banks.
package snax_tcdm_pkg;

  localparam int unsigned DefAddrWidth  = 48;
  localparam int unsigned DefDataWidth  = 64;
  localparam int unsigned DefStrbWidth  = DefDataWidth / 8;
  localparam int unsigned DefPorts      = 16;
  localparam int unsigned DefNrBanks    = 32;
  localparam int unsigned DefBankDepth  = 512;
  localparam int unsigned DefWordOffset = $clog2(DefStrbWidth);
  localparam int unsigned DefBankBits   = $clog2(DefNrBanks);
  localparam int unsigned DefRowBits    = $clog2(DefBankDepth);

  typedef logic [DefAddrWidth-1:0] addr_t;
  typedef logic [DefDataWidth-1:0] data_t;
  typedef logic [DefStrbWidth-1:0] strb_t;
  typedef logic [3:0]              amo_t;
  typedef logic [0:0]              user_t;

  typedef struct packed {
    addr_t addr;
    logic  write;
    amo_t  amo;
    data_t data;
    strb_t strb;
    user_t user;
  } snax_req_chan_t;

  typedef struct packed {
    snax_req_chan_t q;
    logic           q_valid;
  } snax_req_t;

  typedef struct packed {
    data_t data;
  } snax_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    snax_rsp_chan_t p;
    logic           p_valid;
  } snax_rsp_t;

endpackage

// File: rtl/snax_tcdm_bank.sv
// Single-port, byte-strobed word memory with a registered (one-cycle) read.
module snax_tcdm_bank
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned BankDepth = DefBankDepth,
  localparam int unsigned RowW     = $clog2(BankDepth),
  localparam int unsigned StrbW    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 en,
  input  logic                 we,
  input  logic [RowW-1:0]      row,
  input  logic [DataWidth-1:0] wdata,
  input  logic [StrbW-1:0]     strb,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [BankDepth];

  // Contents are deliberately not reset; rdata is qualified by the caller.
  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < StrbW; i++)
          if (strb[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/snax_tcdm_responder.sv
// Banked TCDM responder: per-bank round-robin arbitration over requester ports.
// Optional saturating conflict counter under SNAX_TCDM_CONFLICT_CNT_EN.
module snax_tcdm_responder
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned AddrWidth     = DefAddrWidth,
  parameter int unsigned DataWidth     = DefDataWidth,
  parameter int unsigned SnaxTcdmPorts = DefPorts,
  parameter int unsigned NrBanks       = DefNrBanks,
  parameter int unsigned BankDepth     = DefBankDepth,
  parameter type tcdm_req_t = snax_req_t,
  parameter type tcdm_rsp_t = snax_rsp_t
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  tcdm_req_t [SnaxTcdmPorts-1:0] snax_tcdm_req_i,
  output tcdm_rsp_t [SnaxTcdmPorts-1:0] snax_tcdm_rsp_o
`ifdef SNAX_TCDM_CONFLICT_CNT_EN
  ,
  output logic [31:0]                   conflict_cnt_o
`endif
);

  localparam int unsigned WordOff = $clog2(DataWidth / 8);
  localparam int unsigned BankW   = $clog2(NrBanks);
  localparam int unsigned RowW    = $clog2(BankDepth);
  localparam int unsigned PortW   = (SnaxTcdmPorts > 1) ? $clog2(SnaxTcdmPorts) : 1;

  logic [SnaxTcdmPorts-1:0]            valid, is_write, ready, rd_vld, unused_q;
  logic [SnaxTcdmPorts-1:0][BankW-1:0] port_bank, rd_bank;
  logic [SnaxTcdmPorts-1:0][RowW-1:0]  port_row;
  logic [NrBanks-1:0][SnaxTcdmPorts-1:0] bank_gnt;
  logic [NrBanks-1:0][DataWidth-1:0]     bank_rdata;

  for (genvar p = 0; p < SnaxTcdmPorts; p++) begin : g_port
    logic [AddrWidth-1:0] addr;
    assign addr          = snax_tcdm_req_i[p].q.addr;
    assign valid[p]      = snax_tcdm_req_i[p].q_valid & rst_ni;
    assign is_write[p]   = snax_tcdm_req_i[p].q.write;
    assign port_bank[p]  = addr[WordOff +: BankW];
    // Bits above the row field are ignored, so rows wrap.
    assign port_row[p]   = addr[WordOff+BankW +: RowW];
    assign unused_q[p]   = ^{snax_tcdm_req_i[p].q.amo, snax_tcdm_req_i[p].q.user,
                             addr[AddrWidth-1:WordOff+BankW+RowW], addr[WordOff-1:0]};
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    logic [SnaxTcdmPorts-1:0] breq, gnt;
    logic [PortW-1:0]         ptr, win, idx;
    logic                     any;

    for (genvar q = 0; q < SnaxTcdmPorts; q++) begin : g_req
      assign breq[q] = valid[q] && (port_bank[q] == BankW'(b));
    end

    // First requester at or above the pointer, wrapping.
    always_comb begin
      any = 1'b0;
      win = '0;
      idx = '0;
      gnt = '0;
      for (int k = 0; k < SnaxTcdmPorts; k++) begin
        idx = PortW'((int'(ptr) + k) % SnaxTcdmPorts);
        if (!any && breq[idx]) begin
          any = 1'b1;
          win = idx;
        end
      end
      if (any) gnt[win] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni)   ptr <= '0;
      else if (any)  ptr <= (int'(win) == SnaxTcdmPorts - 1) ? '0 : win + 1'b1;
    end

    assign bank_gnt[b] = gnt;

    snax_tcdm_bank #(.DataWidth(DataWidth), .BankDepth(BankDepth)) i_bank (
      .clk_i (clk_i),
      .en    (any),
      .we    (is_write[win]),
      .row   (port_row[win]),
      .wdata (snax_tcdm_req_i[win].q.data),
      .strb  (snax_tcdm_req_i[win].q.strb),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    ready = '0;
    for (int b = 0; b < NrBanks; b++) ready = ready | bank_gnt[b];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_vld  <= '0;
      rd_bank <= '0;
    end else begin
      rd_vld  <= ready & ~is_write;
      rd_bank <= port_bank;
    end
  end

  // Reset also masks a response already in flight, not just the next one.
  always_comb begin
    for (int p = 0; p < SnaxTcdmPorts; p++) begin
      snax_tcdm_rsp_o[p]         = '0;
      snax_tcdm_rsp_o[p].q_ready = ready[p];
      snax_tcdm_rsp_o[p].p_valid = rd_vld[p] & rst_ni;
      if (rd_vld[p] && rst_ni) snax_tcdm_rsp_o[p].p.data = bank_rdata[rd_bank[p]];
    end
  end

`ifdef SNAX_TCDM_CONFLICT_CNT_EN
  logic [31:0] denied;
  logic [32:0] cnt_sum;

  always_comb begin
    denied = '0;
    for (int p = 0; p < SnaxTcdmPorts; p++) denied = denied + 32'(valid[p] & ~ready[p]);
  end

  assign cnt_sum = {1'b0, conflict_cnt_o} + {1'b0, denied};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) conflict_cnt_o <= '0;
    else         conflict_cnt_o <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
`endif

endmodule
